// File: rtl/soc_system_pio_ext.sv
// soc_system_pio_ext: parametrised Avalon-MM PIO for the HPS lightweight bridge.
// It provides WIDTH-bit data, per-bit direction and an input synchroniser.
// It also has edge capture with write-1-to-clear and a maskable level irq.
// Read data is registered, so it appears one cycle after the address.
// Optional feature macro: SOC_SYSTEM_PIO_EXT_BITSET_EN enables the atomic
// OUTSET (4) and OUTCLR (5) registers.
module soc_system_pio_ext #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    typedef enum logic [2:0] {
        REG_DATA     = 3'd0,
        REG_DIR      = 3'd1,
        REG_IRQ_MASK = 3'd2,
        REG_EDGE     = 3'd3,
        REG_OUTSET   = 3'd4,
        REG_OUTCLR   = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_addr_e;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] data_out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wdata;
    logic [31:0]      rd_next;
    logic             wr_en;
    reg_addr_e        reg_sel;
    logic             unused_wr_hi;

    assign wr_en    = chipselect & ~write_n;
    assign reg_sel  = reg_addr_e'(address);
    assign wdata    = writedata[WIDTH-1:0];
    assign sync_in  = sync_q[SYNC_STAGES-1];
    assign out_port = data_out_q;
    assign oe       = dir_q;
    assign irq      = |(edge_q & mask_q);
    // Writedata bits above WIDTH are deliberately ignored.
    assign unused_wr_hi = &{1'b0, writedata};

    // The input synchroniser chain, plus the previous synchronised value used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_in;
        end
    end

    // Edge detection on the synchronised input and the write-1-to-clear mask.
    always_comb begin
        edge_det = '0;
        case (EDGE_TYPE)
            0:       edge_det = sync_in & ~prev_q;
            1:       edge_det = ~sync_in & prev_q;
            default: edge_det = (sync_in & ~prev_q) | (~sync_in & prev_q);
        endcase
        edge_clr = (wr_en && reg_sel == REG_EDGE) ? wdata : '0;
    end

    // Edge capture register. When a clear and a new edge hit the same bit, the set wins.
    always_ff @(posedge clk) begin
        if (reset) edge_q <= '0;
        else       edge_q <= (edge_q & ~edge_clr) | edge_det;
    end

    // Software-writable control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= RESET_VALUE[WIDTH-1:0];
            dir_q      <= '0;
            mask_q     <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_DATA:     data_out_q <= wdata;
                REG_DIR:      dir_q      <= wdata;
                REG_IRQ_MASK: mask_q     <= wdata;
`ifdef SOC_SYSTEM_PIO_EXT_BITSET_EN
                REG_OUTSET:   data_out_q <= data_out_q | wdata;
                REG_OUTCLR:   data_out_q <= data_out_q & ~wdata;
`endif
                default: ;
            endcase
        end
    end

    // Read mux. It uses the current address and state, and bits above WIDTH read as 0.
    always_comb begin
        rd_next = '0;
        case (reg_sel)
            REG_DATA:     rd_next[WIDTH-1:0] = (sync_in & ~dir_q) | (data_out_q & dir_q);
            REG_DIR:      rd_next[WIDTH-1:0] = dir_q;
            REG_IRQ_MASK: rd_next[WIDTH-1:0] = mask_q;
            REG_EDGE:     rd_next[WIDTH-1:0] = edge_q;
`ifdef SOC_SYSTEM_PIO_EXT_BITSET_EN
            REG_OUTSET,
            REG_OUTCLR:   rd_next[WIDTH-1:0] = data_out_q;
`endif
            default:      rd_next = '0;
        endcase
    end

    // Registered read data. It updates every cycle, whether or not chipselect is asserted.
    always_ff @(posedge clk) begin
        if (reset) readdata <= '0;
        else       readdata <= rd_next;
    end

endmodule

// File: tb/tb_soc_system_pio_ext.sv
// Self-checking bench for soc_system_pio_ext (WIDTH=8, EDGE_TYPE=0, SYNC_STAGES=2).
// Expected read data is queued when a read is issued.
// It is popped and compared when readdata is valid, one cycle later.
module tb_soc_system_pio_ext;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  in_port = '0;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] exp_q [$];
    logic        rd_issue = 1'b0;
    logic        rd_vld   = 1'b0;
    logic [31:0] bs_exp_set, bs_exp_clr, bs_exp_rd4, bs_exp_rd5;

    soc_system_pio_ext #(
        .WIDTH(8),
        .EDGE_TYPE(0),
        .RESET_VALUE(32'h0),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .in_port(in_port),
        .out_port(out_port),
        .oe(oe),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Read data is valid in the cycle after the address was presented.
    always @(posedge clk) rd_vld <= rd_issue;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (exp_q.size() == 0) check("rd_underflow", 32'd1, 32'd0);
            else                   check("readdata", readdata, exp_q.pop_front());
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        exp_q.push_back(exp);
        rd_issue = 1'b1;
        @(posedge clk); #1;
        rd_issue = 1'b0; chipselect = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SOC_SYSTEM_PIO_EXT_BITSET_EN
        bs_exp_set = 32'h3F; bs_exp_clr = 32'h3C; bs_exp_rd4 = 32'h3F; bs_exp_rd5 = 32'h3C;
`else
        bs_exp_set = 32'h0F; bs_exp_clr = 32'h0F; bs_exp_rd4 = 32'h00; bs_exp_rd5 = 32'h00;
`endif
        // Reset state
        idle(3);
        check("rst_out_port", 32'(out_port), 32'h0);
        check("rst_oe", 32'(oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_readdata", readdata, 32'h0);
        reset = 1'b0;
        bus_read(3'd3, 32'h0);

        // Data register, direction and the read mux
        in_port = 8'h3C;
        bus_write(3'd0, 32'hA5);
        check("wr_out_port", 32'(out_port), 32'hA5);
        idle(2);
        bus_read(3'd0, 32'h3C);
        bus_write(3'd1, 32'hFF);
        check("dir_oe", 32'(oe), 32'hFF);
        bus_read(3'd0, 32'hA5);
        bus_read(3'd1, 32'hFF);
        bus_write(3'd1, 32'h0F);
        bus_read(3'd0, 32'h35);
        bus_read(3'd3, 32'h3C);
        bus_write(3'd3, 32'hFF);
        bus_read(3'd3, 32'h00);

        // Rising edge on bit 0 with mask 0x01, checking latency and clear
        bus_write(3'd1, 32'h00);
        in_port = 8'h00;
        idle(4);
        bus_read(3'd3, 32'h00);
        bus_write(3'd2, 32'h01);
        in_port = 8'h01;
        idle(2);
        check("edge_lat_e2_irq", 32'(irq), 32'h0);
        idle(1);
        check("edge_lat_e3_irq", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h01);
        bus_write(3'd3, 32'h01);
        check("w1c_irq", 32'(irq), 32'h0);
        bus_read(3'd3, 32'h00);

        // A clear in the same cycle as a new edge: the set wins
        in_port = 8'h00;
        idle(4);
        bus_write(3'd3, 32'h01);
        bus_read(3'd3, 32'h00);
        in_port = 8'h01;
        idle(2);
        bus_write(3'd3, 32'h01);
        check("set_wins_irq", 32'(irq), 32'h1);
        bus_read(3'd3, 32'h01);

        // The mask gates irq
        in_port = 8'h00;
        idle(4);
        bus_write(3'd2, 32'h00);
        bus_write(3'd3, 32'hFF);
        in_port = 8'hFF;
        idle(4);
        bus_read(3'd3, 32'hFF);
        check("mask0_irq", 32'(irq), 32'h0);
        bus_write(3'd2, 32'h80);
        check("mask80_irq", 32'(irq), 32'h1);

        // Bit set and clear registers
        bus_write(3'd0, 32'h0F);
        check("data_0f", 32'(out_port), 32'h0F);
        bus_write(3'd4, 32'h30);
        check("outset", 32'(out_port), bs_exp_set);
        bus_read(3'd4, bs_exp_rd4);
        bus_write(3'd5, 32'h03);
        check("outclr", 32'(out_port), bs_exp_clr);
        bus_read(3'd5, bs_exp_rd5);

        // Reserved addresses read 0 and ignore writes
        bus_write(3'd6, 32'hFF);
        bus_write(3'd7, 32'hFF);
        check("rsvd_wr", 32'(out_port), bs_exp_clr);
        bus_read(3'd6, 32'h0);
        bus_read(3'd7, 32'h0);

        // Reset while a write is in progress
        bus_write(3'd1, 32'hAA);
        reset = 1'b1;
        bus_write(3'd0, 32'h55);
        check("midrst_out_port", 32'(out_port), 32'h0);
        check("midrst_oe", 32'(oe), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_readdata", readdata, 32'h0);
        reset = 1'b0;
        idle(3);
        bus_read(3'd0, 32'hFF);
        bus_read(3'd1, 32'h00);
        bus_read(3'd2, 32'h00);

        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
